// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_sub_pkg;

  // Default operand/result width when the instantiating block does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Operation sequencing: wait for operands, shift bits through the cell, present result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Latency: combinational.
// Backpressure: none (pure logic).
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit is the parity of all three inputs, the same as the adder sum.
  assign d    = a ^ b ^ bin;
  // Borrow out when b exceeds a outright, or when they match and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock; optional signed overflow (SERIAL_SUB_SIGNED_OVF_EN).
// Latency: accept in cycle 0, result valid from cycle WIDTH+1; one op per WIDTH+2 cycles at best.
// Backpressure: result held in DONE until out_ready_i; no new operands accepted until back in IDLE.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q, borrow_q;
  logic             d_bit, bout_bit;
  logic             last_bit, accept;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  full_subtractor_bit u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Counter stops at the last bit index, so it never wraps.
  assign last_bit = (cnt_q == LAST_BIT);

  // Next-state and handshake outputs derived from the current state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, serial shift datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a_i;
      b_sr  <= b_i;
      br_q  <= 1'b0;
      cnt_q <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q <= a_i[WIDTH-1];
      b_msb_q <= b_i[WIDTH-1];
`endif
    end else if (state_q == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br_q   <= bout_bit;
      diff_q <= {d_bit, diff_q[WIDTH-1:1]};
      if (last_bit) begin
        // Final borrow and overflow are published together with the MSB of diff.
        borrow_q <= bout_bit;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ovf_q    <= (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences, random ops.
// Latency: expects result in cycle WIDTH+1 counting the accept cycle as cycle 0.
// Backpressure: holds out_ready_i low in DONE and checks result stability.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_i;
  logic         in_ready;
  logic [W-1:0] a_i, b_i;
  logic         out_valid;
  logic         out_ready_i;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         overflow;
`endif

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready    (in_ready),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid   (out_valid),
    .out_ready_i (out_ready_i),
    .diff        (diff),
    .borrow      (borrow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .overflow    (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    int           hold;
    bit           pulse;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic and signed range test.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic br, output logic ov);
    int ua, ub, sa, sb, r;
    ua = int'(a);
    ub = int'(b);
    d  = W'((ua - ub + (1 << W)) % (1 << W));
    br = (ua < ub);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    r  = sa - sb;
    ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input int hold, input bit pulse, input string tag);
    int n;
    int k;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    a_i         = a;
    b_i         = b;
    in_valid_i  = 1'b1;
    out_ready_i = (hold == 0);
    tick();                       // accept edge closes cycle 0
    in_valid_i = 1'b0;
    a_i        = ~a;              // operands must already be latched
    b_i        = ~b;
    k = 1;
    chk({tag, ".in_ready_run"}, in_ready, 0);
    while (!out_valid && k < W + 10) begin
      if (pulse && k == 3) begin
        in_valid_i = 1'b1;
        a_i        = 8'hFF;
        b_i        = 8'h00;
      end else begin
        in_valid_i = 1'b0;
      end
      tick();
      k++;
    end
    in_valid_i = 1'b0;
    chk({tag, ".out_valid"}, out_valid, 1);
    if (!out_valid) return;
    chk({tag, ".latency"}, k, W + 1);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".borrow"}, borrow, eb);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk({tag, ".overflow"}, overflow, eo);
`else
    if (eo === 1'bx) $display("note: unexpected unknown overflow expectation");
`endif
    for (int h = 1; h < hold; h++) begin
      tick();
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_diff"}, diff, ed);
      chk({tag, ".hold_borrow"}, borrow, eb);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({tag, ".post_valid"}, out_valid, 0);
    chk({tag, ".post_in_ready"}, in_ready, 1);
    chk({tag, ".idle_diff"}, diff, ed);
  endtask

  initial begin
    logic [W-1:0] ra, rb, md;
    logic         mb, mo;
    int           hits;

    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0, 1'b0};
    vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 5, 1'b0};
    vecs[5] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 0, 1'b1};
    vecs[6] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 1'b0};
    vecs[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, 1'b0};
    vecs[8] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 2, 1'b0};

    rst         = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    a_i         = '0;
    b_i         = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset.in_ready", in_ready, 1);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.diff", diff, 0);
    chk("reset.borrow", borrow, 0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("reset.overflow", overflow, 0);
`endif

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf,
             vecs[i].hold, vecs[i].pulse, $sformatf("vec%0d", i));

    // Abort while bit 3 is being processed: no result may ever appear.
    a_i        = 8'h5A;
    b_i        = 8'h23;
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.in_ready", in_ready, 1);
    chk("abort.out_valid", out_valid, 0);
    chk("abort.diff", diff, 0);
    chk("abort.borrow", borrow, 0);
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) hits++;
      tick();
    end
    chk("abort.no_result", hits, 0);
    out_ready_i = 1'b0;
    run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 0, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      model(ra, rb, md, mb, mo);
      run_op(ra, rb, md, mb, mo, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
